// File: rtl/hex_overlay_pkg.sv
// hex_overlay_pkg
// Shared constants, types and helpers for the hex value overlay.
//   GLYPH_W / GLYPH_H : glyph cell size in pixels
//   CNT_W             : width of the pixel and line position counters
package hex_overlay_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 8;
  localparam int CNT_W   = 10;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [GLYPH_W-1:0] glyph_row_t;

  localparam cnt_t CNT_MAX = '1;

  // Background row: every pixel at 1 (no ink).
  localparam glyph_row_t ROW_BLANK = '1;

  // Saturating position counter increment.
  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == CNT_MAX) ? c : c + cnt_t'(1);
  endfunction

  // Nibble shown in cell d; cell 0 carries the most significant nibble.
  function automatic logic [3:0] digit_nibble(input logic [31:0] val, input logic [2:0] d);
    return 4'(val >> (5'd28 - {d, 2'b00}));
  endfunction

endpackage

// File: rtl/hex_overlay_if.sv
// hex_overlay_if
// Video timing strobes, the word to display and the overlay result.
//   master : video timing source (drives strobes/value/enable, reads overlay)
//   slave  : the overlay block
interface hex_overlay_if;

  logic        pix_en;
  logic        line_start;
  logic        frame_start;
  logic [31:0] value;
  logic        enable;
  logic        ovl_active;
  logic        ovl_pixel;

  modport master (
    output pix_en, line_start, frame_start, value, enable,
    input  ovl_active, ovl_pixel
  );

  modport slave (
    input  pix_en, line_start, frame_start, value, enable,
    output ovl_active, ovl_pixel
  );

endinterface

// File: rtl/fontGen.sv
// fontGen
// Glyph ROM for the hex digits 0-F. Characters 0..15 are the hex digits,
// every other code is blank. Row 0 is the top row; bit 7 is the leftmost
// pixel. Output polarity: 0 = ink, 1 = background.
//   chr     : character code
//   row     : glyph row (0 = top)
//   dataOut : glyph row pixels
module fontGen
  import hex_overlay_pkg::*;
(
  input  logic [5:0]         chr,
  input  logic [2:0]         row,
  output logic [GLYPH_W-1:0] dataOut
);

  // Ink-positive patterns, top row in the most significant byte.
  logic [63:0] bits;

  always_comb begin
    bits = '0;
    if (chr[5:4] == 2'b00) begin
      case (chr[3:0])
        4'h0:    bits = 64'h003C666E76663C00;
        4'h1:    bits = 64'h0018381818187E00;
        4'h2:    bits = 64'h003C660C18307E00;
        4'h3:    bits = 64'h003C661C06663C00;
        4'h4:    bits = 64'h000C1C2C4C7E0C00;
        4'h5:    bits = 64'h007E607C06663C00;
        4'h6:    bits = 64'h003C607C66663C00;
        4'h7:    bits = 64'h007E060C18303000;
        4'h8:    bits = 64'h003C663C66663C00;
        4'h9:    bits = 64'h003C663E060C3800;
        4'hA:    bits = 64'h00183C667E666600;
        4'hB:    bits = 64'h007C667C66667C00;
        4'hC:    bits = 64'h003C666060663C00;
        4'hD:    bits = 64'h00786C66666C7800;
        4'hE:    bits = 64'h007E607C60607E00;
        4'hF:    bits = 64'h007E607C60606000;
        default: bits = '0;
      endcase
    end
  end

  // Row r sits at bit offset 8*(7-r); ~row is 7-row for a 3-bit row.
  assign dataOut = ~bits[{~row, 3'b000} +: 8];

endmodule

// File: rtl/hex_overlay.sv
// hex_overlay
// Draws a DIGITS-wide hexadecimal rendering of a 32-bit word into a video
// stream as a 1-bit glyph overlay. The word and the on/off control are
// captured once per frame so the picture never tears mid-frame.
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   bus    : slave side of hex_overlay_if
//            pix_en, line_start, frame_start, value, enable (in)
//            ovl_active, ovl_pixel (out, registered, updated per emitted pixel)
module hex_overlay
  import hex_overlay_pkg::*;
#(
  parameter int X0     = 16,
  parameter int Y0     = 16,
  parameter int DIGITS = 8
) (
  input  logic          clk,
  input  logic          reset,
  hex_overlay_if.slave  bus
);

  localparam cnt_t X0_C = cnt_t'(X0);
  localparam cnt_t Y0_C = cnt_t'(Y0);

  // Window bounds kept at 32 bits so large parameters cannot wrap.
  localparam logic [31:0] X_LO = 32'(X0);
  localparam logic [31:0] X_HI = 32'(X0 + GLYPH_W * DIGITS);
  localparam logic [31:0] Y_LO = 32'(Y0);
  localparam logic [31:0] Y_HI = 32'(Y0 + GLYPH_H);

  cnt_t        hcnt_q, hcnt_d;
  cnt_t        vcnt_q, vcnt_d;
  logic [31:0] snap_val_q, snap_val_d;
  logic        snap_en_q, snap_en_d;
  glyph_row_t  shreg_q, shreg_d;
  logic        ovl_active_q, ovl_active_d;
  logic        ovl_pixel_q, ovl_pixel_d;

  logic        emit;
  logic        in_x, in_y, in_win;
  logic        cell_start;
  logic [2:0]  cell_idx;
  logic [2:0]  glyph_row_idx;
  logic [3:0]  nibble;
  glyph_row_t  glyph;

  // A line_start cycle never produces a pixel, so pixel 0 is the first
  // pix_en that follows it.
  assign emit = bus.pix_en & ~bus.line_start;

  // Saturated counters land outside the window whatever X0/Y0/DIGITS are.
  assign in_x = (32'(hcnt_q) >= X_LO) && (32'(hcnt_q) < X_HI) && (hcnt_q != CNT_MAX);
  assign in_y = (32'(vcnt_q) >= Y_LO) && (32'(vcnt_q) < Y_HI) && (vcnt_q != CNT_MAX);
  assign in_win = snap_en_q && in_x && in_y;

  assign cell_idx      = 3'((hcnt_q - X0_C) >> 3);
  assign cell_start    = ((hcnt_q[2:0] - X0_C[2:0]) == 3'd0);
  assign glyph_row_idx = 3'(vcnt_q - Y0_C);
  assign nibble        = digit_nibble(snap_val_q, cell_idx);

  fontGen u_font (
    .chr     ({2'b00, nibble}),
    .row     (glyph_row_idx),
    .dataOut (glyph)
  );

  always_comb begin
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    snap_val_d   = snap_val_q;
    snap_en_d    = snap_en_q;
    shreg_d      = shreg_q;
    ovl_active_d = ovl_active_q;
    ovl_pixel_d  = ovl_pixel_q;

    if (bus.line_start) begin
      hcnt_d = '0;
    end else if (bus.pix_en) begin
      hcnt_d = sat_inc(hcnt_q);
    end

    // frame_start wins over a coincident line_start: that line is line 0.
    if (bus.frame_start) begin
      vcnt_d = '0;
    end else if (bus.line_start) begin
      vcnt_d = sat_inc(vcnt_q);
    end

    if (bus.frame_start) begin
      snap_val_d = bus.value;
      snap_en_d  = bus.enable;
    end

    if (emit) begin
      if (in_win) begin
        ovl_active_d = 1'b1;
        // First pixel of a cell comes straight from the ROM; the rest of
        // the row is shifted out, back-filling with background.
        if (cell_start) begin
          ovl_pixel_d = glyph[GLYPH_W-1];
          shreg_d     = {glyph[GLYPH_W-2:0], 1'b1};
        end else begin
          ovl_pixel_d = shreg_q[GLYPH_W-1];
          shreg_d     = {shreg_q[GLYPH_W-2:0], 1'b1};
        end
      end else begin
        ovl_active_d = 1'b0;
        ovl_pixel_d  = 1'b1;
        shreg_d      = ROW_BLANK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q       <= '0;
      vcnt_q       <= CNT_MAX;
      snap_val_q   <= '0;
      snap_en_q    <= 1'b0;
      shreg_q      <= ROW_BLANK;
      ovl_active_q <= 1'b0;
      ovl_pixel_q  <= 1'b1;
    end else begin
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      snap_val_q   <= snap_val_d;
      snap_en_q    <= snap_en_d;
      shreg_q      <= shreg_d;
      ovl_active_q <= ovl_active_d;
      ovl_pixel_q  <= ovl_pixel_d;
    end
  end

  assign bus.ovl_active = ovl_active_q;
  assign bus.ovl_pixel  = ovl_pixel_q;

endmodule

// File: tb/tb_hex_overlay.sv
module tb_hex_overlay;

  localparam int X0     = 16;
  localparam int Y0     = 16;
  localparam int DIGITS = 8;
  localparam int NPIX   = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hex_overlay_if ovl ();

  hex_overlay #(.X0(X0), .Y0(Y0), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ovl)
  );

  // Ink-positive glyphs for 0-F, top row in the most significant byte.
  logic [63:0] FONT [16] = '{
    64'h003C666E76663C00, 64'h0018381818187E00, 64'h003C660C18307E00, 64'h003C661C06663C00,
    64'h000C1C2C4C7E0C00, 64'h007E607C06663C00, 64'h003C607C66663C00, 64'h007E060C18303000,
    64'h003C663C66663C00, 64'h003C663E060C3800, 64'h00183C667E666600, 64'h007C667C66667C00,
    64'h003C666060663C00, 64'h00786C66666C7800, 64'h007E607C60607E00, 64'h007E607C60606000
  };

  int nchecks = 0;
  int nerr    = 0;

  // Reference model state (screen position, frame snapshot, expected outputs).
  int          m_h = 0, m_v = 1023;
  logic [31:0] m_sv = '0;
  logic        m_se = 1'b0;
  logic        e_act = 1'b0, e_pix = 1'b1;

  logic line_act [128];
  logic line_pix [128];
  logic ref_act  [128];
  logic ref_pix  [128];
  logic any_act, any_ink;

  function automatic logic in_win(input int h, input int v, input logic se);
    return se && h >= X0 && h < X0 + 8 * DIGITS && v >= Y0 && v < Y0 + 8
           && h != 1023 && v != 1023;
  endfunction

  // Pixel at screen position (h,v) read directly from the font table.
  function automatic logic glyph_pix(input logic [31:0] sv, input int h, input int v);
    int rel, dgt, col, nib, r;
    logic [63:0] g;
    logic [7:0]  rb;
    rel = h - X0;
    dgt = rel / 8;
    col = rel % 8;
    nib = int'((sv >> (28 - 4 * dgt)) & 32'hF);
    r   = (v - Y0) % 8;
    g   = FONT[nib];
    rb  = 8'(g >> (8 * (7 - r)));
    return ~rb[7 - col];
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic pe, input logic ls, input logic fs,
                            input logic [31:0] val, input logic en);
    if (rst) begin
      m_h = 0; m_v = 1023; m_sv = '0; m_se = 1'b0; e_act = 1'b0; e_pix = 1'b1;
    end else begin
      if (pe && !ls) begin
        if (in_win(m_h, m_v, m_se)) begin
          e_act = 1'b1;
          e_pix = glyph_pix(m_sv, m_h, m_v);
        end else begin
          e_act = 1'b0;
          e_pix = 1'b1;
        end
      end
      if (ls) m_h = 0;
      else if (pe && m_h < 1023) m_h++;
      if (fs) m_v = 0;
      else if (ls && m_v < 1023) m_v++;
      if (fs) begin
        m_sv = val;
        m_se = en;
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic pe, input logic ls, input logic fs,
                     input logic [31:0] val, input logic en);
    reset           = rst;
    ovl.pix_en      = pe;
    ovl.line_start  = ls;
    ovl.frame_start = fs;
    ovl.value       = val;
    ovl.enable      = en;
    @(posedge clk);
    #1;
    model_step(rst, pe, ls, fs, val, en);
    chk1("ovl_active", ovl.ovl_active, e_act);
    chk1("ovl_pixel", ovl.ovl_pixel, e_pix);
  endtask

  // One line: line_start (optionally with frame_start), then npix pixels.
  // gap: idle cycles before each pixel (-1 = random 0..2).
  // rst_at: pixel index replaced by a reset cycle (-1 = none).
  task automatic run_line(input logic fs, input logic [31:0] val, input logic en,
                          input int npix, input int gap, input int rst_at);
    int g;
    cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, fs, val, en);
    for (int i = 0; i < npix; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k < g; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, val, en);
      if (i == rst_at) begin
        cyc(1'b1, 1'b1, 1'b0, 1'b0, val, en);
        chk1("reset_mid_act", ovl.ovl_active, 1'b0);
        chk1("reset_mid_pix", ovl.ovl_pixel, 1'b1);
      end else begin
        cyc(1'b0, 1'b1, 1'b0, 1'b0, val, en);
        if (i < 128) begin
          line_act[i] = ovl.ovl_active;
          line_pix[i] = ovl.ovl_pixel;
        end
        any_act = any_act | ovl.ovl_active;
        any_ink = any_ink | ~ovl.ovl_pixel;
      end
    end
  endtask

  // frame_start on line 0, then lines 1..n-1.
  task automatic run_lines(input int n, input logic [31:0] val, input logic en);
    run_line(1'b1, val, en, NPIX, 0, -1);
    for (int l = 1; l < n; l++) run_line(1'b0, val, en, NPIX, 0, -1);
  endtask

  initial begin
    logic [31:0] rv;
    logic [7:0]  a_row1;
    a_row1 = 8'b1110_0111;

    reset = 1'b1;
    ovl.pix_en = 1'b0; ovl.line_start = 1'b0; ovl.frame_start = 1'b0;
    ovl.value = '0; ovl.enable = 1'b0;

    // Reset wins over coincident strobes.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk1("reset_act", ovl.ovl_active, 1'b0);
    chk1("reset_pix", ovl.ovl_pixel, 1'b1);

    // No frame_start yet: dark even with enable high.
    any_act = 1'b0;
    for (int l = 0; l < Y0 + 2; l++) run_line(1'b0, 32'h0123_4567, 1'b1, NPIX, 0, -1);
    chk1("dark_before_frame", any_act, 1'b0);

    // Frame A: 0123_4567.
    run_lines(Y0, 32'h0123_4567, 1'b1);
    run_line(1'b0, 32'h0123_4567, 1'b1, NPIX, 0, -1);
    chk1("win_left_edge_out", line_act[X0 - 1], 1'b0);
    chk1("win_right_edge_out", line_act[X0 + 8 * DIGITS], 1'b0);
    for (int h = X0; h < X0 + 8 * DIGITS; h++) chk1("win_active", line_act[h], 1'b1);
    for (int h = X0; h < X0 + 8; h++) chk1("glyph0_row0", line_pix[h], 1'b1);
    // Input word changes mid-frame; row 1 of '0' must still be shown.
    run_line(1'b0, 32'hFFFF_FFFF, 1'b1, NPIX, 0, -1);
    chk1("snap_hold_p17", line_pix[X0 + 1], 1'b1);
    chk1("snap_hold_p18", line_pix[X0 + 2], 1'b0);

    // Frame B: A000_0000, row 1 of 'A'.
    run_lines(Y0 + 1, 32'hA000_0000, 1'b1);
    run_line(1'b0, 32'hA000_0000, 1'b1, NPIX, 0, -1);
    for (int j = 0; j < 8; j++) chk1("glyphA_row1", line_pix[X0 + j], a_row1[7 - j]);
    run_line(1'b0, 32'hA000_0000, 1'b1, NPIX, 0, -1);
    for (int h = 0; h < 128; h++) begin
      ref_act[h] = line_act[h];
      ref_pix[h] = line_pix[h];
    end

    // Frame C: same word, same line with 3-cycle gaps before every pixel.
    run_lines(Y0 + 2, 32'hA000_0000, 1'b1);
    run_line(1'b0, 32'hA000_0000, 1'b1, NPIX, 3, -1);
    for (int h = 0; h < NPIX; h++) begin
      chk1("gap_act", line_act[h], ref_act[h]);
      chk1("gap_pix", line_pix[h], ref_pix[h]);
    end

    // Frame D: disabled; enable rising mid-frame has no effect.
    any_act = 1'b0; any_ink = 1'b0;
    run_line(1'b1, 32'h8888_8888, 1'b0, NPIX, 0, -1);
    for (int l = 1; l < Y0 + 9; l++) run_line(1'b0, 32'h8888_8888, 1'b1, NPIX, 0, -1);
    chk1("disabled_act", any_act, 1'b0);
    chk1("disabled_ink", any_ink, 1'b0);

    // Frame E: reset at hcnt = 20 inside the window.
    run_lines(Y0, 32'h89AB_CDEF, 1'b1);
    run_line(1'b0, 32'h89AB_CDEF, 1'b1, NPIX, 0, 20);
    any_act = 1'b0;
    for (int l = 0; l < 10; l++) run_line(1'b0, 32'h89AB_CDEF, 1'b1, NPIX, 0, -1);
    chk1("dark_after_reset", any_act, 1'b0);
    run_lines(Y0 + 1, 32'h89AB_CDEF, 1'b1);
    chk1("relit_left", line_act[X0], 1'b1);
    chk1("relit_right", line_act[X0 + 8 * DIGITS - 1], 1'b1);

    // Randomized frames: random word/enable, random pixel gaps, random
    // mid-frame input changes, one very long line to saturate hcnt.
    for (int f = 0; f < 3; f++) begin
      rv = $urandom;
      run_line(1'b1, rv, 1'($urandom_range(0, 3) != 0), $urandom_range(80, 110), -1, -1);
      for (int l = 1; l < Y0 + 9; l++) begin
        if (l == Y0 + 3 && f == 0)
          run_line(1'b0, $urandom, 1'($urandom_range(0, 1)), 1100, 0, -1);
        else
          run_line(1'b0, $urandom, 1'($urandom_range(0, 1)), $urandom_range(80, 110), -1, -1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
